// File: rtl/imm_packer_if.sv
// Handshake bundle for imm_packer: constant in, immediate-field beats out, err pulse.
interface imm_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic [1:0]  in_sel;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_field;
  logic [1:0]  out_kind;
  logic        out_last;
  logic        err;

  modport slave (
    input  in_valid, in_value, in_sel, out_ready,
    output in_ready, out_valid, out_field, out_kind, out_last, err
  );

  modport master (
    output in_valid, in_value, in_sel, out_ready,
    input  in_ready, out_valid, out_field, out_kind, out_last, err
  );
endinterface

// File: rtl/imm_packer.sv
// Packs a 32-bit constant into 12/20-bit immediate fields; define IMM_PACK_SPLIT_EN
// to split non-fitting 12-bit requests into an upper-20 / lower-12 beat pair.
module imm_packer (
  input logic        clk,
  input logic        rst_n,
  imm_packer_if.slave bus
);
  logic [31:0] w_v;
  logic        w_fits12, w_fits20, w_single, w_out_free, w_acc, w_in_ready;
  logic        r_out_valid, r_err;
  logic [19:0] r_out_field;
  logic [1:0]  r_out_kind;

  assign w_v        = bus.in_value;
  assign w_fits12   = (&w_v[31:11]) | ~(|w_v[31:11]);
  assign w_fits20   = (&w_v[31:19]) | ~(|w_v[31:19]);
  assign w_single   = (bus.in_sel == 2'b11) ? w_fits20 : w_fits12;
  assign w_out_free = !r_out_valid || bus.out_ready;
  assign w_acc      = bus.in_valid && w_in_ready;

`ifdef IMM_PACK_SPLIT_EN
  typedef enum logic [1:0] {S_IDLE, S_HI, S_LO} state_t;
  state_t      r_state;
  logic [11:0] r_lo;
  logic [1:0]  r_lo_kind;
  logic        r_out_last;
  logic [19:0] w_hi;
  logic        w_split;

  // Rounding the upper part by bit 11 compensates for the sign-extended low field.
  assign w_hi    = w_v[31:12] + {19'd0, w_v[11]};
  assign w_split = (bus.in_sel != 2'b11) && !w_fits12;
  // LO holds the final beat, so a new constant may enter as that beat leaves.
  assign w_in_ready = rst_n && (r_state != S_HI) && w_out_free;
  assign bus.out_last = r_out_last;
`else
  assign w_in_ready = rst_n && w_out_free;
  assign bus.out_last = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_field <= 20'd0;
      r_out_kind  <= 2'b00;
      r_err       <= 1'b0;
`ifdef IMM_PACK_SPLIT_EN
      r_out_last  <= 1'b0;
      r_state     <= S_IDLE;
      r_lo        <= 12'd0;
      r_lo_kind   <= 2'b00;
`endif
    end else begin
      r_err <= 1'b0;
      if (w_acc && w_single) begin
        r_out_valid <= 1'b1;
        r_out_field <= (bus.in_sel == 2'b11) ? w_v[19:0] : {8'h00, w_v[11:0]};
        r_out_kind  <= bus.in_sel;
`ifdef IMM_PACK_SPLIT_EN
        r_out_last  <= 1'b1;
        r_state     <= S_IDLE;
`endif
      end
`ifdef IMM_PACK_SPLIT_EN
      else if (w_acc && w_split) begin
        r_out_valid <= 1'b1;
        r_out_field <= w_hi;
        r_out_kind  <= 2'b11;
        r_out_last  <= 1'b0;
        r_lo        <= w_v[11:0];
        r_lo_kind   <= bus.in_sel;
        r_state     <= S_HI;
      end else if (r_state == S_HI) begin
        if (bus.out_ready) begin
          r_out_field <= {8'h00, r_lo};
          r_out_kind  <= r_lo_kind;
          r_out_last  <= 1'b1;
          r_state     <= S_LO;
        end
      end
`endif
      else if (w_acc) begin
        r_out_valid <= 1'b0;
        r_err       <= 1'b1;
`ifdef IMM_PACK_SPLIT_EN
        r_state     <= S_IDLE;
`endif
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
`ifdef IMM_PACK_SPLIT_EN
        r_state     <= S_IDLE;
`endif
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_field = r_out_field;
  assign bus.out_kind  = r_out_kind;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_imm_packer.sv
// Bench for imm_packer: directed literal cases plus random traffic against a beat-queue model.
module tb_imm_packer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imm_packer_if bus();
  imm_packer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [19:0] f;
    logic [1:0]  k;
    logic        l;
  } beat_t;

  beat_t q[$];
  bit    err_exp = 1'b0;
  bit    armed = 1'b0;
  int    checks = 0;
  int    failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic bit exp_ready();
    return rst_n && (q.size() == 0 || (q.size() == 1 && bus.out_ready));
  endfunction

  // Reference behaviour from signed-range arithmetic rather than bit patterns.
  function automatic void model_accept(input logic [31:0] v, input logic [1:0] s);
    int sv;
    logic [31:0] t;
    bit f12, f20;
    sv  = $signed(v);
    f12 = (sv >= -2048) && (sv < 2048);
    f20 = (sv >= -524288) && (sv < 524288);
    if (s == 2'b11) begin
      if (f20) q.push_back('{f: v[19:0], k: 2'b11, l: 1'b1});
      else err_exp = 1'b1;
    end else if (f12) begin
      q.push_back('{f: {8'h00, v[11:0]}, k: s, l: 1'b1});
    end else begin
`ifdef IMM_PACK_SPLIT_EN
      t = v + 32'h800;
      q.push_back('{f: t[31:12], k: 2'b11, l: 1'b0});
      q.push_back('{f: {8'h00, v[11:0]}, k: s, l: 1'b1});
`else
      t = 32'd0;
      err_exp = 1'b1;
`endif
    end
  endfunction

  always @(posedge clk) begin
    bit rdy, hs;
    if (!rst_n) begin
      q.delete();
      err_exp = 1'b0;
    end else begin
      rdy = exp_ready();
      hs  = (q.size() != 0) && bus.out_ready;
      if (hs) void'(q.pop_front());
      err_exp = 1'b0;
      if (rdy && bus.in_valid) model_accept(bus.in_value, bus.in_sel);
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("m_out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() != 0});
      chk("m_in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ready()});
      chk("m_err", {31'd0, bus.err}, {31'd0, err_exp});
      if (q.size() != 0 && bus.out_valid) begin
        chk("m_field", {12'd0, bus.out_field}, {12'd0, q[0].f});
        chk("m_kind", {30'd0, bus.out_kind}, {30'd0, q[0].k});
        chk("m_last", {31'd0, bus.out_last}, {31'd0, q[0].l});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] v, input logic [1:0] s);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_value = v;
    bus.in_sel   = s;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    if (!ok) chk("offer_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_beat(input string nm, input logic [19:0] f, input logic [1:0] k, input logic l);
    @(negedge clk);
    chk({nm, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({nm, "_field"}, {12'd0, bus.out_field}, {12'd0, f});
    chk({nm, "_kind"}, {30'd0, bus.out_kind}, {30'd0, k});
    chk({nm, "_last"}, {31'd0, bus.out_last}, {31'd0, l});
    chk({nm, "_err"}, {31'd0, bus.err}, 32'd0);
    step();
  endtask

  function automatic logic [31:0] rand_val();
    logic [31:0] r;
    logic [31:0] edges [10];
    edges = '{32'h0000_07FF, 32'h0000_0800, 32'hFFFF_F800, 32'hFFFF_F7FF, 32'h0007_FFFF,
              32'h0008_0000, 32'hFFF8_0000, 32'hFFF7_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    r = $urandom;
    case ($urandom_range(0, 3))
      0: return {{20{r[11]}}, r[11:0]};
      1: return {{12{r[19]}}, r[19:0]};
      2: return r;
      default: return edges[$urandom_range(0, 9)];
    endcase
  endfunction

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_value  = 32'd0;
    bus.in_sel    = 2'b00;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_field", {12'd0, bus.out_field}, 32'd0);
    chk("rst_kind", {30'd0, bus.out_kind}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
`ifdef IMM_PACK_SPLIT_EN
    chk("rst_last", {31'd0, bus.out_last}, 32'd0);
`endif
    step();
    rst_n = 1'b1;
    armed = 1'b1;
    bus.out_ready = 1'b1;

    offer(32'hFFFF_F800, 2'b00);
    expect_beat("t1", 20'h00800, 2'b00, 1'b1);

`ifdef IMM_PACK_SPLIT_EN
    offer(32'h1234_5FFF, 2'b01);
    expect_beat("t2_hi", 20'h12346, 2'b11, 1'b0);
    expect_beat("t2_lo", 20'h00FFF, 2'b01, 1'b1);

    bus.out_ready = 1'b0;
    offer(32'h0000_0800, 2'b10);
    expect_beat("t3_hi_hold", 20'h00001, 2'b11, 1'b0);
    bus.out_ready = 1'b1;
    expect_beat("t3_hi", 20'h00001, 2'b11, 1'b0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_stall_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("t3_stall_field", {12'd0, bus.out_field}, 32'h00800);
      step();
    end
    bus.out_ready = 1'b1;
    expect_beat("t3_lo", 20'h00800, 2'b10, 1'b1);
    @(negedge clk);
    chk("t3_drained", {31'd0, bus.out_valid}, 32'd0);
    step();
`endif

    offer(32'h0008_0000, 2'b11);
    @(negedge clk);
    chk("t4_err", {31'd0, bus.err}, 32'd1);
    chk("t4_novalid", {31'd0, bus.out_valid}, 32'd0);
    step();
    @(negedge clk);
    chk("t4_err_pulse", {31'd0, bus.err}, 32'd0);
    step();
    offer(32'hFFF8_0000, 2'b11);
    expect_beat("t4b", 20'h80000, 2'b11, 1'b1);

    offer(32'h0000_1000, 2'b00);
`ifdef IMM_PACK_SPLIT_EN
    expect_beat("t5_hi", 20'h00001, 2'b11, 1'b0);
    expect_beat("t5_lo", 20'h00000, 2'b00, 1'b1);
`else
    @(negedge clk);
    chk("t5_err", {31'd0, bus.err}, 32'd1);
    chk("t5_novalid", {31'd0, bus.out_valid}, 32'd0);
    step();
`endif

    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_value = 32'(i + 1);
      bus.in_sel   = 2'b00;
      @(negedge clk);
      chk("t5_b2b_ready", {31'd0, bus.in_ready}, 32'd1);
      if (i > 0) chk("t5_b2b_field", {12'd0, bus.out_field}, 32'(i));
      step();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t5_b2b_final", {12'd0, bus.out_field}, 32'd4);
    step();

`ifdef IMM_PACK_SPLIT_EN
    bus.out_ready = 1'b0;
    offer(32'h1234_5FFF, 2'b00);
    expect_beat("t6_hi_hold", 20'h12346, 2'b11, 1'b0);
    bus.out_ready = 1'b1;
    expect_beat("t6_hi", 20'h12346, 2'b11, 1'b0);
    bus.out_ready = 1'b0;
    expect_beat("t6_lo", 20'h00FFF, 2'b00, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_ready", {31'd0, bus.in_ready}, 32'd0);
    step();
    @(negedge clk);
    chk("t6_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("t6_rst_err", {31'd0, bus.err}, 32'd0);
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_post_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("t6_post_ready", {31'd0, bus.in_ready}, 32'd1);
      step();
    end
`endif

    for (int c = 0; c < 3000; c++) begin
      rst_n         = ($urandom_range(0, 299) != 0);
      bus.in_valid  = $urandom_range(0, 1) == 1;
      bus.in_value  = rand_val();
      bus.in_sel    = 2'($urandom_range(0, 3));
      bus.out_ready = $urandom_range(0, 9) < 7;
      step();
    end
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
